// File: rtl/rv_decode_pkg.sv
// ---------------------------------------------------------------------------
// rv_decode_pkg : shared encodings for the RV32I decoder and the 16-bit ALU
// Revision      : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    CA_ADD   = 5'd0,  CA_SUB  = 5'd1,  CA_SLL  = 5'd2,  CA_SLT  = 5'd3,
    CA_SLTU  = 5'd4,  CA_XOR  = 5'd5,  CA_SRL  = 5'd6,  CA_SRA  = 5'd7,
    CA_OR    = 5'd8,  CA_AND  = 5'd9,  CA_PASSB = 5'd10, CA_ADDPC = 5'd11,
    CA_BEQ   = 5'd12, CA_BNE  = 5'd13, CA_BLT  = 5'd14, CA_BGE  = 5'd15,
    CA_BLTU  = 5'd16, CA_BGEU = 5'd17, CA_NOP  = 5'd31
  } ctrl_alu_e;

  localparam logic [1:0] RW_ALU = 2'b00;
  localparam logic [1:0] RW_MEM = 2'b01;
  localparam logic [1:0] RW_PC4 = 2'b10;
  localparam logic [1:0] RW_IMM = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] AC_AND  = 3'b000;
  localparam logic [2:0] AC_OR   = 3'b001;
  localparam logic [2:0] AC_ADD  = 3'b010;
  localparam logic [2:0] AC_XOR  = 3'b011;
  localparam logic [2:0] AC_NOR  = 3'b100;
  localparam logic [2:0] AC_SLTU = 3'b101;
  localparam logic [2:0] AC_SUB  = 3'b110;
  localparam logic [2:0] AC_SLT  = 3'b111;

  // Shared funct3 map for OP and OP-IMM; SUB only exists in the register form.
  function automatic ctrl_alu_e arith_map(input logic [2:0] f3, input logic f7b,
                                          input logic is_reg);
    ctrl_alu_e c;
    case (f3)
      3'b000:  c = (is_reg && f7b) ? CA_SUB : CA_ADD;
      3'b001:  c = CA_SLL;
      3'b010:  c = CA_SLT;
      3'b011:  c = CA_SLTU;
      3'b100:  c = CA_XOR;
      3'b101:  c = f7b ? CA_SRA : CA_SRL;
      3'b110:  c = CA_OR;
      default: c = CA_AND;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu16_core.sv
// ---------------------------------------------------------------------------
// alu16_core : combinational scalar ALU with zero detect
// Revision   : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu16_core
  import rv_decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_ctrl,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      AC_AND:  o_result = i_a & i_b;
      AC_OR:   o_result = i_a | i_b;
      AC_ADD:  o_result = i_a + i_b;
      AC_XOR:  o_result = i_a ^ i_b;
      AC_NOR:  o_result = ~(i_a | i_b);
      AC_SLTU: o_result = {{(DATA_W-1){1'b0}}, w_lt_u};
      AC_SUB:  o_result = i_a - i_b;
      default: o_result = {{(DATA_W-1){1'b0}}, w_lt_s};
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/rv_decode_alu.sv
// ---------------------------------------------------------------------------
// rv_decode_alu : registered RV32I decoder plus independent 16-bit ALU
// Revision      : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rv_decode_alu
  import rv_decode_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_src2,
  input  logic [2:0]        alu_ctrl,
  output logic [4:0]        control_alu,
  output logic              write_out,
  output logic [1:0]        reg_write,
  output logic              alu_op,
  output logic              read_data_mem,
  output logic              write_data_mem,
  output logic [1:0]        size_data_mem,
  output logic              jal,
  output logic              jalr,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic        w_f7b;
  logic        w_unused_bits;

  ctrl_alu_e   w_ctrl;
  logic        w_wr, w_aop, w_rd, w_wm, w_jal, w_jalr;
  logic [1:0]  w_rsel, w_size;

  logic [DATA_W-1:0] w_res;
  logic              w_zero;

  assign w_opc         = inst[6:0];
  assign w_f3          = inst[14:12];
  assign w_f7b         = inst[30];
  assign w_unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  // Defaults describe the illegal-instruction NOP; legal paths override them.
  always_comb begin
    w_ctrl = CA_NOP;
    w_wr   = 1'b0;
    w_rsel = RW_ALU;
    w_aop  = 1'b0;
    w_rd   = 1'b0;
    w_wm   = 1'b0;
    w_size = SZ_BYTE;
    w_jal  = 1'b0;
    w_jalr = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_ctrl = CA_PASSB; w_wr = 1'b1; w_rsel = RW_IMM; w_aop = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl = CA_ADDPC; w_wr = 1'b1; w_rsel = RW_ALU; w_aop = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl = CA_ADD; w_wr = 1'b1; w_rsel = RW_PC4; w_aop = 1'b1; w_jal = 1'b1;
      end
      OPC_JALR: begin
        if (w_f3 == 3'b000) begin
          w_ctrl = CA_ADD; w_wr = 1'b1; w_rsel = RW_PC4; w_aop = 1'b1; w_jalr = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (w_f3)
          3'b000:  w_ctrl = CA_BEQ;
          3'b001:  w_ctrl = CA_BNE;
          3'b100:  w_ctrl = CA_BLT;
          3'b101:  w_ctrl = CA_BGE;
          3'b110:  w_ctrl = CA_BLTU;
          3'b111:  w_ctrl = CA_BGEU;
          default: w_ctrl = CA_NOP;
        endcase
      end
      OPC_LOAD: begin
        if (w_f3 != 3'b011 && w_f3 != 3'b110 && w_f3 != 3'b111) begin
          w_ctrl = CA_ADD; w_rd = 1'b1; w_wr = 1'b1; w_rsel = RW_MEM;
          w_aop  = 1'b1;   w_size = w_f3[1:0];
        end
      end
      OPC_STORE: begin
        if (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010) begin
          w_ctrl = CA_ADD; w_wm = 1'b1; w_aop = 1'b1; w_size = w_f3[1:0];
        end
      end
      OPC_OPIMM: begin
        w_ctrl = arith_map(w_f3, w_f7b, 1'b0);
        w_wr = 1'b1; w_rsel = RW_ALU; w_aop = 1'b1;
      end
      OPC_OP: begin
        w_ctrl = arith_map(w_f3, w_f7b, 1'b1);
        w_wr = 1'b1; w_rsel = RW_ALU; w_aop = 1'b0;
      end
      default: w_ctrl = CA_NOP;
    endcase
  end

  alu16_core #(.DATA_W(DATA_W)) u_alu (
    .i_a      (alu_src1),
    .i_b      (alu_src2),
    .i_ctrl   (alu_ctrl),
    .o_result (w_res),
    .o_zero   (w_zero)
  );

  logic [4:0]        r_ctrl;
  logic              r_wr, r_aop, r_rd, r_wm, r_jal, r_jalr, r_zero;
  logic [1:0]        r_rsel, r_size;
  logic [DATA_W-1:0] r_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= CA_NOP;
      r_wr   <= 1'b0;
      r_rsel <= 2'b00;
      r_aop  <= 1'b0;
      r_rd   <= 1'b0;
      r_wm   <= 1'b0;
      r_size <= 2'b00;
      r_jal  <= 1'b0;
      r_jalr <= 1'b0;
      r_res  <= '0;
      r_zero <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl;
      r_wr   <= w_wr;
      r_rsel <= w_rsel;
      r_aop  <= w_aop;
      r_rd   <= w_rd;
      r_wm   <= w_wm;
      r_size <= w_size;
      r_jal  <= w_jal;
      r_jalr <= w_jalr;
      r_res  <= w_res;
      r_zero <= w_zero;
    end
  end

  assign control_alu    = r_ctrl;
  assign write_out      = r_wr;
  assign reg_write      = r_rsel;
  assign alu_op         = r_aop;
  assign read_data_mem  = r_rd;
  assign write_data_mem = r_wm;
  assign size_data_mem  = r_size;
  assign jal            = r_jal;
  assign jalr           = r_jalr;
  assign alu_result     = r_res;
  assign zero           = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_rv_decode_alu.sv
// ---------------------------------------------------------------------------
// tb_rv_decode_alu : directed self-checking bench for rv_decode_alu
// Revision         : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rv_decode_alu;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       inst;
  logic [DATA_W-1:0] alu_src1, alu_src2;
  logic [2:0]        alu_ctrl;
  logic [4:0]        control_alu;
  logic              write_out, alu_op, read_data_mem, write_data_mem, jal, jalr, zero;
  logic [1:0]        reg_write, size_data_mem;
  logic [DATA_W-1:0] alu_result;

  int n_total = 0;
  int n_bad   = 0;

  rv_decode_alu #(.DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst           (inst),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .alu_ctrl       (alu_ctrl),
    .control_alu    (control_alu),
    .write_out      (write_out),
    .reg_write      (reg_write),
    .alu_op         (alu_op),
    .read_data_mem  (read_data_mem),
    .write_data_mem (write_data_mem),
    .size_data_mem  (size_data_mem),
    .jal            (jal),
    .jalr           (jalr),
    .alu_result     (alu_result),
    .zero           (zero)
  );

  always #5 clk = ~clk;

  // {write_out, reg_write, alu_op, read_data_mem, write_data_mem, size, jal, jalr}
  logic [9:0] w_flags;
  assign w_flags = {write_out, reg_write, alu_op, read_data_mem, write_data_mem,
                    size_data_mem, jal, jalr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic dec(input string tag, input logic [31:0] ins,
                     input logic [4:0] e_ctrl, input logic [9:0] e_flags);
    @(negedge clk);
    inst = ins;
    @(posedge clk);
    #1;
    chk({tag, ".ctrl"},  {27'd0, control_alu}, {27'd0, e_ctrl});
    chk({tag, ".flags"}, {22'd0, w_flags},     {22'd0, e_flags});
  endtask

  task automatic alu(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] op, input logic [15:0] e_res, input logic e_zero);
    @(negedge clk);
    alu_src1 = a;
    alu_src2 = b;
    alu_ctrl = op;
    @(posedge clk);
    #1;
    chk({tag, ".res"},  {16'd0, alu_result}, {16'd0, e_res});
    chk({tag, ".zero"}, {31'd0, zero},       {31'd0, e_zero});
  endtask

  initial begin
    rst_n    = 1'b0;
    inst     = 32'h8000_0037;
    alu_src1 = 16'h0000;
    alu_src2 = 16'h0000;
    alu_ctrl = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ctrl",  {27'd0, control_alu}, 32'd31);
    chk("rst.flags", {22'd0, w_flags},     32'd0);
    chk("rst.res",   {16'd0, alu_result},  32'd0);
    chk("rst.zero",  {31'd0, zero},        32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("lui.ctrl",  {27'd0, control_alu}, 32'd10);
    chk("lui.flags", {22'd0, w_flags},     {22'd0, 10'b1_11_1_0_0_00_0_0});

    dec("auipc", 32'h8000_0017, 5'd11, 10'b1_00_1_0_0_00_0_0);
    dec("jal",   32'h8020_006F, 5'd0,  10'b1_10_1_0_0_00_1_0);
    dec("jalr",  32'h8000_0067, 5'd0,  10'b1_10_1_0_0_00_0_1);
    dec("beq",   32'h8000_00E3, 5'd12, 10'b0_00_0_0_0_00_0_0);
    dec("lb",    32'h8000_0003, 5'd0,  10'b1_01_1_1_0_00_0_0);
    dec("sb",    32'h8000_0823, 5'd0,  10'b0_00_1_0_1_00_0_0);
    dec("sltiu", 32'h8000_3013, 5'd4,  10'b1_00_1_0_0_00_0_0);
    dec("srai",  32'h4100_5013, 5'd7,  10'b1_00_1_0_0_00_0_0);
    dec("zero",  32'h0000_0000, 5'd31, 10'b0_00_0_0_0_00_0_0);
    dec("sub",   32'h4000_0033, 5'd1,  10'b1_00_0_0_0_00_0_0);
    dec("lw",    32'h0000_2003, 5'd0,  10'b1_01_1_1_0_10_0_0);
    dec("lhu",   32'h0000_5003, 5'd0,  10'b1_01_1_1_0_01_0_0);
    dec("sh",    32'h0000_1023, 5'd0,  10'b0_00_1_0_1_01_0_0);
    dec("brill", 32'h0000_2063, 5'd31, 10'b0_00_0_0_0_00_0_0);
    dec("jalrbad", 32'h0000_1067, 5'd31, 10'b0_00_0_0_0_00_0_0);
    dec("bgeu",  32'h0000_7063, 5'd17, 10'b0_00_0_0_0_00_0_0);
    dec("srli",  32'h0000_5013, 5'd6,  10'b1_00_1_0_0_00_0_0);
    dec("addi",  32'h4000_0013, 5'd0,  10'b1_00_1_0_0_00_0_0);

    alu("and",  16'h000C, 16'h800A, 3'b000, 16'h0008, 1'b0);
    alu("slt0", 16'h000C, 16'h000A, 3'b111, 16'h0000, 1'b1);
    alu("sub",  16'h000C, 16'h000A, 3'b110, 16'h0002, 1'b0);
    alu("addw", 16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b1);
    alu("slt1", 16'h800A, 16'h000C, 3'b111, 16'h0001, 1'b0);
    alu("sltu", 16'h800A, 16'h000C, 3'b101, 16'h0000, 1'b1);
    alu("or",   16'h00F0, 16'h000F, 3'b001, 16'h00FF, 1'b0);
    alu("xor",  16'h00FF, 16'h0F0F, 3'b011, 16'h0FF0, 1'b0);
    alu("subw", 16'h0000, 16'h0001, 3'b110, 16'hFFFF, 1'b0);
    alu("nor",  16'h00F0, 16'h000F, 3'b100, 16'hFF00, 1'b0);

    // Asynchronous reset between edges: outputs must clear without a clock.
    inst = 32'h8000_0037;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.ctrl",  {27'd0, control_alu}, 32'd31);
    chk("arst.flags", {22'd0, w_flags},     32'd0);
    chk("arst.res",   {16'd0, alu_result},  32'd0);
    chk("arst.zero",  {31'd0, zero},        32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv_decode_alu.md
Name: rv_decode_alu

Overview:
- Registered RV32I instruction decoder plus an independent 16-bit scalar ALU, sharing one clock and reset.
- The decoder turns a 32-bit instruction into datapath control signals.
- The ALU computes AND/OR/ADD/XOR/NOR/SLTU/SUB/SLT on two 16-bit operands and flags a zero result.
- Sits at the decode stage of the teaching CPU. Each half has 1-cycle latency.

Parameters:
- DATA_W, 16, ALU operand/result width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- inst  in  32  instruction word
- alu_src1  in  DATA_W  ALU operand A
- alu_src2  in  DATA_W  ALU operand B
- alu_ctrl  in  3  ALU operation select
- control_alu  out  5  datapath ALU operation code
- write_out  out  1  register-file write enable
- reg_write  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 immediate
- alu_op  out  1  operand-B select: 1 immediate, 0 rs2
- read_data_mem  out  1  load enable
- write_data_mem  out  1  store enable
- size_data_mem  out  2  access size: 00 byte, 01 half, 10 word
- jal  out  1  JAL instruction
- jalr  out  1  JALR instruction
- alu_result  out  DATA_W  ALU result
- zero  out  1  alu_result == 0

Behaviour:
- Reset and latency:
  - All outputs are flops, loaded on every rising clk.
  - While rst_n is low, every output is 0 except control_alu = 5'b11111 (NOP).
  - Output at edge N reflects inputs sampled at edge N. No stall and no enable.
- control_alu codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 ADDPC, 12 BEQ, 13 BNE, 14 BLT, 15 BGE, 16 BLTU, 17 BGEU, 31 NOP.
- Decode by opcode inst[6:0], f3 = inst[14:12], f7b = inst[30]:
  - 0110111 LUI: PASSB, write_out 1, reg_write 11, alu_op 1.
  - 0010111 AUIPC: ADDPC, write_out 1, reg_write 00, alu_op 1.
  - 1101111 JAL: ADD, write_out 1, reg_write 10, alu_op 1, jal 1.
  - 1100111 JALR (f3 = 000): ADD, write_out 1, reg_write 10, alu_op 1, jalr 1.
  - 1100011 branch: f3 000/001/100/101/110/111 map to BEQ/BNE/BLT/BGE/BLTU/BGEU. write_out 0, alu_op 0. f3 010/011 are illegal.
  - 0000011 load (f3 000, 001, 010, 100, 101): ADD, read_data_mem 1, write_out 1, reg_write 01, alu_op 1, size_data_mem = f3[1:0].
  - 0100011 store (f3 000, 001, 010): ADD, write_data_mem 1, alu_op 1, size_data_mem = f3[1:0], write_out 0.
  - 0010011 ALU-immediate: write_out 1, reg_write 00, alu_op 1.
    - f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND, 001 SLL.
    - f3 101: SRA if f7b = 1, else SRL.
  - 0110011 ALU-register: same f3 map as ALU-immediate, alu_op 0. f3 000 with f7b = 1 gives SUB.
  - Any other opcode or illegal f3: NOP, all other outputs 0. Instruction 0x00000000 is illegal.
  - size_data_mem is 00 for non-memory instructions.
- ALU (alu_ctrl):
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT (signed).
  - ADD/SUB wrap modulo 2^DATA_W; no carry or overflow output.
  - SLT/SLTU produce 1 or 0, zero-extended to DATA_W.
  - zero is computed from the same-cycle result and registered alongside it.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode constants;
  - the control_alu enum (including NOP = 31);
  - reg_write select and size_data_mem encodings;
  - alu_ctrl encodings.
- One combinational sub-module, alu16_core (operands, ctrl, result, zero). The decoder is combinational logic in the top, followed by the output register.

Test Plan:
- Reset: hold rst_n low with inst = 0x80000037 -> control_alu 11111, all other outputs 0. Release; next edge -> control_alu 01010, write_out 1, reg_write 11, alu_op 1.
- Decode sweep, one instruction per cycle:
  - 0x80000017 -> control_alu 01011, write_out 1, reg_write 00, alu_op 1.
  - 0x8020006F -> jal 1, reg_write 10, write_out 1.
  - 0x80000067 -> jalr 1, reg_write 10.
  - 0x800000E3 -> control_alu 01100, write_out 0, alu_op 0.
- Memory:
  - 0x80000003 -> read_data_mem 1, reg_write 01, size 00.
  - 0x80000823 -> write_data_mem 1, write_out 0, size 00.
- Immediate ALU and illegal:
  - 0x80003013 -> control_alu 00100 (SLTU), alu_op 1.
  - 0x41005013 -> control_alu 00111 (SRA).
  - 0x00000000 -> control_alu 11111, all other outputs 0.
- ALU with alu_src1 = 0x000C:
  - alu_src2 = 0x800A, AND -> alu_result 0x0008, zero 0.
  - alu_src2 = 0x000A, SLT -> 0x0000, zero 1.
  - alu_src2 = 0x000A, SUB -> 0x0002, zero 0.
- ALU edges:
  - 0xFFFF ADD 0x0001 -> 0x0000, zero 1.
  - 0x800A SLT 0x000C -> 0x0001.
  - 0x800A SLTU 0x000C -> 0x0000.
  - 0x00F0 NOR 0x000F -> 0xFF00.
  - Assert rst_n mid-sequence -> outputs clear immediately, without waiting for a clock edge.
